wptr_full_lvl: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/ptr_sync.sv | 25 ++
 rtl/wptr_full_lvl.sv | 89 ++++++++
 tb/tb_wptr_full_lvl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic.
// Gray/binary conversions work on a 32-bit container; callers size-cast to their pointer width.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the low bits exact.
    function automatic logic [31:0] gray2bin(input logic [31:0] i_gray);
        logic [31:0] r_bin;
        r_bin[31] = i_gray[31];
        for (int i = 30; i >= 0; i--) begin
            r_bin[i] = r_bin[i+1] ^ i_gray[i];
        end
        return r_bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Pure flop chain with no logic between stages.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer, full, almost-full, fill level and sticky overflow for a dual-clock FIFO.
// Status is derived from the synchronised read pointer, so it is conservative during sync latency.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic                 wr_inc,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    input  logic [ADDR_SIZE:0]   af_thresh,
    input  logic                 ovf_clr,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 wr_ovf
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_ptr;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    logic [PW-1:0] w_wq_rptr;
    logic [PW-1:0] w_wq_rbin;
    logic          w_accept;
    logic [PW-1:0] w_binnext;
    logic [PW-1:0] w_graynext;
    logic [PW-1:0] w_level_next;
    logic          w_full_val;
    logic          w_af_next;
    logic          w_ovf_next;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (wr_clk),
        .i_rst_n (wr_rstn),
        .i_d     (rd_ptr_gray),
        .o_q     (w_wq_rptr)
    );

    assign w_wq_rbin    = PW'(gray2bin(32'(w_wq_rptr)));
    assign w_accept     = wr_inc & ~r_full;
    assign w_binnext    = r_wr_bin + PW'(w_accept);
    assign w_graynext   = PW'(bin2gray(32'(w_binnext)));
    assign w_level_next = w_binnext - w_wq_rbin;

    // Full when the next write pointer has lapped the read pointer by exactly one depth.
    assign w_full_val = (w_graynext == {~w_wq_rptr[ADDR_SIZE:ADDR_SIZE-1], w_wq_rptr[ADDR_SIZE-2:0]});
    assign w_af_next  = (w_level_next >= af_thresh);
    // A rejected write outranks a simultaneous clear so no overflow event is lost.
    assign w_ovf_next = (wr_inc & r_full) | (r_ovf & ~ovf_clr);

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            r_wr_bin      <= '0;
            r_wr_ptr      <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_wr_bin      <= w_binnext;
            r_wr_ptr      <= w_graynext;
            r_full        <= w_full_val;
            r_almost_full <= w_af_next;
            r_level       <= w_level_next;
            r_ovf         <= w_ovf_next;
        end
    end

    assign wr_addr        = r_wr_bin[ADDR_SIZE-1:0];
    assign wr_ptr         = r_wr_ptr;
    assign wr_full        = r_full;
    assign wr_almost_full = r_almost_full;
    assign wr_level       = r_level;
    assign wr_ovf         = r_ovf;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl: reference model feeds a scoreboard queue, plus directed boundary checks.
module tb_wptr_full_lvl;

    localparam int A     = 4;
    localparam int S     = 2;
    localparam int PW    = A + 1;
    localparam int DEPTH = 2 ** A;
    localparam int MASK  = (2 ** PW) - 1;

    logic          wr_clk = 1'b0;
    logic          wr_rstn = 1'b0;
    logic          wr_inc = 1'b0;
    logic [PW-1:0] rd_ptr_gray = '0;
    logic [PW-1:0] af_thresh = 5'd12;
    logic          ovf_clr = 1'b0;
    logic [A-1:0]  wr_addr;
    logic [PW-1:0] wr_ptr;
    logic          wr_full;
    logic          wr_almost_full;
    logic [PW-1:0] wr_level;
    logic          wr_ovf;

    wptr_full_lvl #(.ADDR_SIZE(A), .SYNC_STAGES(S)) dut (
        .wr_clk         (wr_clk),
        .wr_rstn        (wr_rstn),
        .wr_inc         (wr_inc),
        .rd_ptr_gray    (rd_ptr_gray),
        .af_thresh      (af_thresh),
        .ovf_clr        (ovf_clr),
        .wr_addr        (wr_addr),
        .wr_ptr         (wr_ptr),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_level       (wr_level),
        .wr_ovf         (wr_ovf)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int bin;
        int ptr;
        bit full;
        bit af;
        int level;
        bit ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    int   m_bin;
    int   m_sync[S];
    bit   m_full;
    bit   m_ovf;

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    function automatic int g2b(int g);
        int b = 0;
        for (int s = 0; s < PW; s++) b = b ^ (g >> s);
        return b & MASK;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bin  = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        for (int i = 0; i < S; i++) m_sync[i] = 0;
        sbq.delete();
    endtask

    // Predict the next edge from current inputs, push, advance one edge, pop and compare.
    task automatic tick();
        exp_t e;
        int   acc;
        int   rb;
        acc     = (wr_inc && !m_full) ? 1 : 0;
        e.bin   = (m_bin + acc) & MASK;
        rb      = g2b(m_sync[S-1]);
        e.level = (e.bin - rb) & MASK;
        e.full  = (e.level == DEPTH);
        e.af    = (e.level >= int'(af_thresh));
        e.ovf   = (wr_inc && m_full) || (m_ovf && !ovf_clr);
        e.ptr   = b2g(e.bin);
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = int'(rd_ptr_gray);
        m_bin  = e.bin;
        m_full = e.full;
        m_ovf  = e.ovf;
        sbq.push_back(e);
        @(posedge wr_clk);
        #1;
        e = sbq.pop_front();
        chk("sb_addr",  32'(wr_addr),        32'(e.bin % DEPTH));
        chk("sb_ptr",   32'(wr_ptr),         32'(e.ptr));
        chk("sb_full",  32'(wr_full),        32'(e.full));
        chk("sb_af",    32'(wr_almost_full), 32'(e.af));
        chk("sb_level", 32'(wr_level),       32'(e.level));
        chk("sb_ovf",   32'(wr_ovf),         32'(e.ovf));
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_addr"},  32'(wr_addr),        0);
        chk({tag, "_ptr"},   32'(wr_ptr),         0);
        chk({tag, "_full"},  32'(wr_full),        0);
        chk({tag, "_af"},    32'(wr_almost_full), 0);
        chk({tag, "_level"}, 32'(wr_level),       0);
        chk({tag, "_ovf"},   32'(wr_ovf),         0);
    endtask

    // Assert reset between edges, check outputs clear without a clock, release on a falling edge.
    task automatic async_reset(string tag);
        #2;
        wr_rstn = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        @(negedge wr_clk);
        wr_rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rd_bin;
        int   occ;
        logic [PW-1:0] prev_ptr;
        logic [A-1:0]  prev_addr;
        logic prev_full;
        logic prev_inc;
        bit   saw_wrap;

        model_reset();
        #1;
        chk_all_zero("reset");
        #12;
        wr_rstn = 1'b1;

        // Fill an empty FIFO with the read pointer parked at zero.
        wr_inc = 1'b1;
        repeat (DEPTH) tick();
        chk("fill_full",  32'(wr_full),  1);
        chk("fill_level", 32'(wr_level), 16);
        chk("fill_addr",  32'(wr_addr),  0);
        chk("fill_ptr",   32'(wr_ptr),   32'h18);

        // Writes while full are rejected and flag overflow.
        tick();
        chk("ovf_set", 32'(wr_ovf), 1);
        tick();
        tick();
        chk("full_ptr_hold", 32'(wr_ptr), 32'h18);
        wr_inc  = 1'b0;
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(wr_ovf), 0);
        wr_inc  = 1'b1;
        ovf_clr = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(wr_ovf), 1);
        wr_inc  = 1'b0;
        ovf_clr = 1'b0;

        // Read advance of 4 reaches full/level after SYNC_STAGES+1 edges, not earlier.
        rd_ptr_gray = PW'(b2g(4));
        tick();
        chk("rd4_full_e1", 32'(wr_full), 1);
        tick();
        chk("rd4_full_e2", 32'(wr_full), 1);
        chk("rd4_lvl_e2",  32'(wr_level), 16);
        tick();
        chk("rd4_full_e3", 32'(wr_full), 0);
        chk("rd4_lvl_e3",  32'(wr_level), 12);

        // Almost-full thresholds.
        @(negedge wr_clk);
        af_thresh   = '0;
        rd_ptr_gray = '0;
        wr_rstn     = 1'b0;
        #1;
        chk_all_zero("rst_af");
        model_reset();
        @(negedge wr_clk);
        wr_rstn = 1'b1;
        tick();
        chk("af_thresh0_first", 32'(wr_almost_full), 1);
        af_thresh = 5'd14;
        tick();
        wr_inc = 1'b1;
        repeat (13) tick();
        chk("af_13", 32'(wr_almost_full), 0);
        tick();
        chk("af_14", 32'(wr_almost_full), 1);
        wr_inc    = 1'b0;
        af_thresh = '0;
        tick();
        chk("af_thr0", 32'(wr_almost_full), 1);
        af_thresh = 5'd17;
        tick();
        chk("af_thr17", 32'(wr_almost_full), 0);

        // Random writes against a trailing read pointer.
        af_thresh = 5'd10;
        rd_bin    = 0;
        saw_wrap  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            wr_inc = ($urandom_range(0, 3) != 0);
            if (rd_bin != m_bin && $urandom_range(0, 1) == 1) rd_bin = (rd_bin + 1) & MASK;
            rd_ptr_gray = PW'(b2g(rd_bin));
            prev_ptr  = wr_ptr;
            prev_addr = wr_addr;
            prev_full = wr_full;
            prev_inc  = wr_inc;
            tick();
            chk("rnd_hamming", 32'($countones(wr_ptr ^ prev_ptr) <= 1), 1);
            occ = (m_bin - rd_bin) & MASK;
            chk("rnd_level_ge_occ", 32'(int'(wr_level) >= occ), 1);
            if (prev_full && prev_inc) chk("rnd_no_accept_full", 32'(wr_addr), 32'(prev_addr));
            if (prev_addr == 4'd15 && wr_addr == 4'd0) saw_wrap = 1'b1;
        end
        chk("rnd_addr_wrap", 32'(saw_wrap), 1);

        // Reset in the middle of a burst, then resume from address zero.
        rd_ptr_gray = '0;
        wr_inc = 1'b1;
        tick();
        tick();
        async_reset("rst_mid");
        tick();
        chk("resume_addr1", 32'(wr_addr), 1);
        tick();
        chk("resume_addr2", 32'(wr_addr), 2);
        wr_inc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
